// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ecc_pkg
// Description : Shared SECDED code definitions: parity-width and column
//               generation functions, injection-mode encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package ecc_pkg;

    localparam int C_MAX_DATA_WIDTH   = 64;
    localparam int C_MAX_PARITY_WIDTH = 8;

    typedef logic [C_MAX_PARITY_WIDTH-1:0] col_t;
    typedef col_t [C_MAX_DATA_WIDTH-1:0]   col_arr_t;

    localparam logic [1:0] C_INJ_NONE   = 2'd0;
    localparam logic [1:0] C_INJ_DATA0  = 2'd1;
    localparam logic [1:0] C_INJ_DATA01 = 2'd2;
    localparam logic [1:0] C_INJ_CHECK0 = 2'd3;

    // Smallest r with 2^(r-1) - r >= data_width.
    function automatic int parity_width(input int data_width);
        int r;
        r = C_MAX_PARITY_WIDTH;
        for (int k = C_MAX_PARITY_WIDTH; k >= 2; k--) begin
            if (((1 << (k - 1)) - k) >= data_width) r = k;
        end
        return r;
    endfunction

    // Data columns: ascending odd-weight values of weight >= 3.
    function automatic col_arr_t gen_columns(input int data_width, input int pwidth);
        col_arr_t cols;
        int       idx;
        int       w;
        cols = '0;
        idx  = 0;
        for (int v = 1; v < (1 << C_MAX_PARITY_WIDTH); v++) begin
            if (v < (1 << pwidth)) begin
                w = 0;
                for (int b = 0; b < C_MAX_PARITY_WIDTH; b++) w += (v >> b) & 1;
                if ((w >= 3) && (w % 2 == 1) && (idx < data_width)) begin
                    cols[idx] = col_t'(v);
                    idx++;
                end
            end
        end
        return cols;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_secded_core.sv
`default_nettype none
// ============================================================================
// Module      : ecc_secded_core
// Description : Combinational SECDED parity generator and syndrome decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_secded_core
    import ecc_pkg::*;
#(
    parameter  int DATA_WIDTH   = 20,
    localparam int PARITY_WIDTH = parity_width(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0]   i_data,
    output logic [PARITY_WIDTH-1:0] o_parity,
    input  logic [PARITY_WIDTH-1:0] i_syndrome,
    output logic [DATA_WIDTH-1:0]   o_flip_mask,
    output logic                    o_sbit,
    output logic                    o_dbit
);

    localparam col_arr_t C_COLS = gen_columns(DATA_WIDTH, PARITY_WIDTH);

    logic [DATA_WIDTH-1:0] w_mask;
    logic                  w_onehot;

    for (genvar j = 0; j < PARITY_WIDTH; j++) begin : g_parity
        logic [DATA_WIDTH-1:0] w_sel;
        for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_sel
            assign w_sel[i] = C_COLS[i][j];
        end
        assign o_parity[j] = ^(i_data & w_sel);
    end

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_mask
        assign w_mask[i] = (i_syndrome == C_COLS[i][PARITY_WIDTH-1:0]);
    end

    // One-hot syndrome means a flipped check bit: flagged but data untouched.
    assign w_onehot    = $onehot(i_syndrome);
    assign o_flip_mask = w_mask;
    assign o_sbit      = (|w_mask) || w_onehot;
    assign o_dbit      = (i_syndrome != '0) && !o_sbit;

endmodule
`default_nettype wire

// File: rtl/ecc_secded_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ecc_secded_pipe
// Description : Registered SECDED encoder with injection, two-stage decode
//               pipeline, saturating error counters and first-error capture.
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_secded_pipe
    import ecc_pkg::*;
#(
    parameter  int DATA_WIDTH   = 20,
    parameter  int CNT_WIDTH    = 16,
    localparam int PARITY_WIDTH = parity_width(DATA_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   enc_data,
    input  logic [1:0]              enc_inj,
    output logic [DATA_WIDTH-1:0]   enc_data_q,
    output logic [PARITY_WIDTH-1:0] enc_parity_q,
    input  logic                    dec_valid,
    output logic                    dec_ready,
    input  logic [DATA_WIDTH-1:0]   dec_data,
    input  logic [PARITY_WIDTH-1:0] dec_parity,
    input  logic                    dec_bypass,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_sbit,
    output logic                    out_dbit,
    output logic [CNT_WIDTH-1:0]    sbit_cnt,
    output logic [CNT_WIDTH-1:0]    dbit_cnt,
    output logic [PARITY_WIDTH-1:0] err_syn,
    output logic                    err_vld,
    input  logic                    cnt_clr
);

    logic [PARITY_WIDTH-1:0] w_enc_parity;
    logic [DATA_WIDTH-1:0]   w_enc_unused_mask;
    logic                    w_enc_unused_sbit;
    logic                    w_enc_unused_dbit;
    logic [DATA_WIDTH-1:0]   w_inj_data;
    logic [PARITY_WIDTH-1:0] w_inj_par;

    logic [PARITY_WIDTH-1:0] w_dec_parity;
    logic [DATA_WIDTH-1:0]   w_flip;
    logic                    w_sbit;
    logic                    w_dbit;
    logic                    w_s2_free;
    logic                    w_xfer;

    logic                    r_s1_valid;
    logic [DATA_WIDTH-1:0]   r_s1_data;
    logic [PARITY_WIDTH-1:0] r_s1_syn;
    logic                    r_s1_bypass;
    logic [PARITY_WIDTH-1:0] r_s2_syn;

    ecc_secded_core #(.DATA_WIDTH(DATA_WIDTH)) u_enc_core (
        .i_data      (enc_data),
        .o_parity    (w_enc_parity),
        .i_syndrome  ('0),
        .o_flip_mask (w_enc_unused_mask),
        .o_sbit      (w_enc_unused_sbit),
        .o_dbit      (w_enc_unused_dbit)
    );

    // Parity is formed on dec_data in stage 1, correction on r_s1_syn in stage 2.
    ecc_secded_core #(.DATA_WIDTH(DATA_WIDTH)) u_dec_core (
        .i_data      (dec_data),
        .o_parity    (w_dec_parity),
        .i_syndrome  (r_s1_syn),
        .o_flip_mask (w_flip),
        .o_sbit      (w_sbit),
        .o_dbit      (w_dbit)
    );

    always_comb begin
        w_inj_data = '0;
        w_inj_par  = '0;
        case (enc_inj)
            C_INJ_DATA0:  w_inj_data[0]   = 1'b1;
            C_INJ_DATA01: w_inj_data[1:0] = 2'b11;
            C_INJ_CHECK0: w_inj_par[0]    = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_data_q   <= '0;
            enc_parity_q <= '0;
        end else begin
            enc_data_q   <= enc_data ^ w_inj_data;
            enc_parity_q <= w_enc_parity ^ w_inj_par;
        end
    end

    assign w_s2_free = !out_valid || out_ready;
    assign dec_ready = !r_s1_valid || w_s2_free;
    assign w_xfer    = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_syn    <= '0;
            r_s1_bypass <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sbit    <= 1'b0;
            out_dbit    <= 1'b0;
            r_s2_syn    <= '0;
        end else begin
            if (dec_ready) begin
                r_s1_valid <= dec_valid;
                if (dec_valid) begin
                    r_s1_data   <= dec_data;
                    r_s1_syn    <= dec_parity ^ w_dec_parity;
                    r_s1_bypass <= dec_bypass;
                end
            end
            if (w_s2_free) begin
                out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    out_data <= r_s1_bypass ? r_s1_data : (r_s1_data ^ w_flip);
                    out_sbit <= !r_s1_bypass && w_sbit;
                    out_dbit <= !r_s1_bypass && w_dbit;
                    r_s2_syn <= r_s1_syn;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbit_cnt <= '0;
            dbit_cnt <= '0;
            err_syn  <= '0;
            err_vld  <= 1'b0;
        end else if (cnt_clr) begin
            sbit_cnt <= '0;
            dbit_cnt <= '0;
            err_syn  <= '0;
            err_vld  <= 1'b0;
        end else if (w_xfer) begin
            if (out_sbit && (sbit_cnt != {CNT_WIDTH{1'b1}})) sbit_cnt <= sbit_cnt + CNT_WIDTH'(1);
            if (out_dbit && (dbit_cnt != {CNT_WIDTH{1'b1}})) dbit_cnt <= dbit_cnt + CNT_WIDTH'(1);
            if ((out_sbit || out_dbit) && !err_vld) begin
                err_syn <= r_s2_syn;
                err_vld <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ecc_secded_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ecc_secded_pipe
// Description : Directed self-checking bench for ecc_secded_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ecc_secded_pipe;

    localparam int DW = 20;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] enc_data;
    logic [1:0]    enc_inj;
    logic          dec_valid;
    logic [DW-1:0] dec_data;
    logic [PW-1:0] dec_parity;
    logic          dec_bypass;
    logic          out_ready;
    logic          cnt_clr;
    logic          sat_clr;

    logic [DW-1:0] enc_data_q,  s_enc_data_q;
    logic [PW-1:0] enc_parity_q, s_enc_parity_q;
    logic          dec_ready,   s_dec_ready;
    logic          out_valid,   s_out_valid;
    logic [DW-1:0] out_data,    s_out_data;
    logic          out_sbit,    s_out_sbit;
    logic          out_dbit,    s_out_dbit;
    logic [15:0]   sbit_cnt,    dbit_cnt;
    logic [1:0]    s_sbit_cnt,  s_dbit_cnt;
    logic [PW-1:0] err_syn,     s_err_syn;
    logic          err_vld,     s_err_vld;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ecc_secded_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .enc_data(enc_data), .enc_inj(enc_inj),
        .enc_data_q(enc_data_q), .enc_parity_q(enc_parity_q),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_data(dec_data),
        .dec_parity(dec_parity), .dec_bypass(dec_bypass),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sbit(out_sbit), .out_dbit(out_dbit), .sbit_cnt(sbit_cnt),
        .dbit_cnt(dbit_cnt), .err_syn(err_syn), .err_vld(err_vld), .cnt_clr(cnt_clr)
    );

    ecc_secded_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enc_data(enc_data), .enc_inj(enc_inj),
        .enc_data_q(s_enc_data_q), .enc_parity_q(s_enc_parity_q),
        .dec_valid(dec_valid), .dec_ready(s_dec_ready), .dec_data(dec_data),
        .dec_parity(dec_parity), .dec_bypass(dec_bypass),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_sbit(s_out_sbit), .out_dbit(s_out_dbit), .sbit_cnt(s_sbit_cnt),
        .dbit_cnt(s_dbit_cnt), .err_syn(s_err_syn), .err_vld(s_err_vld), .cnt_clr(sat_clr)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference parity built from the column rule, independent of the RTL.
    function automatic logic [PW-1:0] model_parity(input logic [DW-1:0] d);
        logic [PW-1:0] p;
        logic [PW-1:0] vv;
        int            idx;
        int            w;
        p   = '0;
        idx = 0;
        for (int v = 1; v < (1 << PW); v++) begin
            vv = PW'(v);
            w  = $countones(vv);
            if ((w >= 3) && (w % 2 == 1) && (idx < DW)) begin
                if (d[idx]) p ^= vv;
                idx++;
            end
        end
        return p;
    endfunction

    task automatic enc_step(input logic [DW-1:0] d, input logic [1:0] inj,
                            input logic [DW-1:0] exp_d, input logic [PW-1:0] exp_p);
        enc_data = d;
        enc_inj  = inj;
        @(negedge clk);
        check("enc_data_q", enc_data_q, exp_d);
        check("enc_parity_q", enc_parity_q, exp_p);
    endtask

    // Returns at the negedge where the word is visible on out_*.
    task automatic launch(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic byp);
        dec_data   = d;
        dec_parity = p;
        dec_bypass = byp;
        dec_valid  = 1'b1;
        @(negedge clk);
        dec_valid  = 1'b0;
        @(negedge clk);
        check("out_valid", out_valid, 1);
    endtask

    task automatic retire(input logic clr);
        cnt_clr = clr;
        sat_clr = clr;
        @(negedge clk);
        cnt_clr = 1'b0;
        sat_clr = 1'b0;
    endtask

    logic [DW-1:0] words [8];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] held;
    logic [PW-1:0] p_abcde;
    int            idx, got, cyc;

    initial begin
        enc_data = '0; enc_inj = '0; dec_valid = 1'b0; dec_data = '0;
        dec_parity = '0; dec_bypass = 1'b0; out_ready = 1'b1;
        cnt_clr = 1'b0; sat_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sbit_cnt", sbit_cnt, 0);
        check("rst_err_vld", err_vld, 0);
        check("rst_err_syn", err_syn, 0);
        rst_n = 1'b1;

        p_abcde = model_parity(20'hABCDE);
        enc_step(20'h00001, 2'd0, 20'h00001, 6'h07);
        enc_step(20'h00000, 2'd0, 20'h00000, 6'h00);
        enc_step(20'h00001, 2'd1, 20'h00000, 6'h07);
        enc_step(20'h00001, 2'd2, 20'h00002, 6'h07);
        enc_step(20'h00001, 2'd3, 20'h00001, 6'h06);
        enc_step(20'hABCDE, 2'd0, 20'hABCDE, p_abcde);

        launch(20'h00001, 6'h00, 1'b0);
        check("t1_data", out_data, 20'h00000);
        check("t1_sbit", out_sbit, 1);
        check("t1_dbit", out_dbit, 0);
        retire(1'b0);
        check("t1_sbit_cnt", sbit_cnt, 1);
        check("t1_err_syn", err_syn, 6'h07);
        check("t1_err_vld", err_vld, 1);

        launch(20'h00003, 6'h00, 1'b0);
        check("t2_data", out_data, 20'h00003);
        check("t2_dbit", out_dbit, 1);
        check("t2_sbit", out_sbit, 0);
        retire(1'b0);
        check("t2_dbit_cnt", dbit_cnt, 1);
        check("t2_err_syn", err_syn, 6'h07);

        launch(20'hABCDE, p_abcde ^ 6'h04, 1'b0);
        check("t3_data", out_data, 20'hABCDE);
        check("t3_sbit", out_sbit, 1);
        retire(1'b0);
        check("t3_sbit_cnt", sbit_cnt, 2);

        launch(20'hABCDE, p_abcde ^ 6'h04, 1'b1);
        check("t4_data", out_data, 20'hABCDE);
        check("t4_flags", {out_sbit, out_dbit}, 2'b00);
        retire(1'b0);
        check("t4_sbit_cnt", sbit_cnt, 2);

        launch(20'h00000, 6'h32, 1'b0);
        check("t5_msb_fix", out_data, 20'h80000);
        check("t5_sbit", out_sbit, 1);
        retire(1'b0);
        check("t5_sbit_cnt", sbit_cnt, 3);

        retire(1'b1);
        check("clr_err_vld", err_vld, 0);
        launch(20'h00000, 6'h34, 1'b0);
        check("t6_dbit", out_dbit, 1);
        check("t6_data", out_data, 20'h00000);
        retire(1'b0);
        check("t6_err_syn", err_syn, 6'h34);
        check("t6_dbit_cnt", dbit_cnt, 1);

        dec_data = 20'h00001; dec_parity = 6'h00; dec_valid = 1'b1;
        @(negedge clk);
        dec_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_dbit_cnt", dbit_cnt, 0);
        check("mrst_err_vld", err_vld, 0);

        words = '{20'h12345, 20'hFEDCB, 20'h00000, 20'hFFFFF,
                  20'hA5A5A, 20'h5A5A5, 20'h0F0F0, 20'h80001};
        idx = 0; got = 0; cyc = 0; held = '0;
        while (got < 8 && cyc < 60) begin
            out_ready = !(cyc >= 4 && cyc <= 6);
            if (idx < 8) begin
                dec_valid  = 1'b1;
                dec_data   = words[idx] ^ (DW'(1) << idx);
                dec_parity = model_parity(words[idx]);
                dec_bypass = 1'b0;
            end else begin
                dec_valid = 1'b0;
            end
            #1;
            if (cyc == 4) begin
                check("stall_ready", dec_ready, 0);
                held = out_data;
            end
            if (cyc == 6) check("stall_hold", out_data, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("stream_extra", exp_q.size(), 1);
                else begin
                    check("stream_data", out_data, exp_q.pop_front());
                    got++;
                end
            end
            if (dec_valid && dec_ready) begin
                exp_q.push_back(words[idx]);
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        dec_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_count", got, 8);
        check("stream_drain", out_valid, 0);
        check("stream_sbit_cnt", sbit_cnt, 8);

        retire(1'b1);
        for (int k = 0; k < 5; k++) begin
            launch(20'h00001, 6'h00, 1'b0);
            retire(1'b0);
        end
        check("sat_sbit_cnt", s_sbit_cnt, 3);
        check("sat_main_cnt", sbit_cnt, 5);
        launch(20'h00001, 6'h00, 1'b0);
        retire(1'b1);
        check("clr_xfer_cnt", s_sbit_cnt, 0);
        check("clr_xfer_vld", s_err_vld, 0);
        check("clr_xfer_main", sbit_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ecc_secded_pipe.md
# ecc_secded_pipe

Parametrised, pipelined SECDED (single-error-correct, double-error-detect) codec for FIFO and RAM protection.
- Encode path registers check bits for an arbitrary data width; decode path is a two-stage valid/ready pipeline that corrects single-bit errors and flags double-bit errors.
- Adds saturating error counters, first-error capture and encode-side error injection.
- Sits between FIFO write/read logic and the storage array; one instance per protected array.

## Interface
- DATA_WIDTH, 20: protected data bits, 4..64.
- CNT_WIDTH, 16: width of each error counter.
- PARITY_WIDTH (localparam): smallest r with 2^(r-1) - r >= DATA_WIDTH. This gives 6 for DATA_WIDTH=20 and 8 for 64.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- enc_data  in  DATA_WIDTH  write data.
- enc_inj  in  2  injection mode: 0 none, 1 flip data bit 0, 2 flip data bits 0 and 1, 3 flip check bit 0.
- enc_data_q  out  DATA_WIDTH  registered write data, after injection.
- enc_parity_q  out  PARITY_WIDTH  registered check bits, computed on un-injected data.
- dec_valid  in  1  read word valid.
- dec_ready  out  1  decode pipeline accepts.
- dec_data  in  DATA_WIDTH  stored data.
- dec_parity  in  PARITY_WIDTH  stored check bits.
- dec_bypass  in  1  pass data uncorrected; suppress flags and counting.
- out_valid  out  1  corrected word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  corrected data.
- out_sbit  out  1  single error (data or check bit) on this word.
- out_dbit  out  1  uncorrectable error on this word.
- sbit_cnt  out  CNT_WIDTH  single-error count.
- dbit_cnt  out  CNT_WIDTH  double-error count.
- err_syn  out  PARITY_WIDTH  syndrome of first error since clear.
- err_vld  out  1  err_syn holds a capture.
- cnt_clr  in  1  clears counters and capture.

## Operation

Code:
- Data bit i's column is the i-th value, in ascending numeric order, among PARITY_WIDTH-bit values of odd weight >= 3.
- Check bit j's column is the one-hot 1<<j.
- parity[j] is the XOR of the data bits whose column has bit j set.

Encode:
- Every cycle, enc_data_q <= enc_data ^ injection mask and enc_parity_q <= parity(enc_data).
- No handshake.

Decode stage 1:
- Registers the data, the syndrome (dec_parity ^ parity(dec_data)) and bypass.

Decode stage 2:
- Syndrome 0: no error.
- Syndrome equals a data column: flip that bit, out_sbit=1.
- Syndrome one-hot: check-bit error, data unchanged, out_sbit=1.
- Any other syndrome (even weight nonzero, or unused odd weight): data unchanged, out_dbit=1.
- Bypass: data unchanged, both flags 0.

Counters:
- Increment on the out_valid && out_ready transfer when the matching flag is set.
- Saturate at all-ones.
- cnt_clr has priority: counters go to 0 and err_vld to 0, and any same-cycle increment or capture is dropped.

Capture:
- On the first flagged transfer while err_vld=0, err_syn <= syndrome and err_vld <= 1.
- Held until cnt_clr.

## Timing
- Reset: all outputs 0, both pipeline valids 0, counters 0, err_syn 0, err_vld 0.
- Encode latency: 1 cycle.
- Decode latency: 2 cycles from dec_valid && dec_ready to out_valid, with no stall.
- Stall rules:
  - Stage 2 holds while out_valid && !out_ready.
  - Stage 1 advances when stage 2 is empty or advancing.
  - dec_ready = !s1_valid || s1_advance (combinational from out_ready).
- Full throughput: one word per cycle when out_ready is held high.
- Under stall, out_data and flags stay stable until accepted.
- Counters and capture update the cycle after the transfer edge.
- Reset asserted mid-stream discards in-flight words; counters are lost.

## Structure
- Package ecc_pkg holds:
  - the parity-width function;
  - the column-generation function, returning an array of PARITY_WIDTH-bit columns;
  - the injection-mode constants.
- One sub-module, ecc_secded_core: combinational parity and syndrome-to-mask/flags logic, instantiated twice (encode parity, decode parity plus correction).
- Pipeline, counters and capture live in the top.

## Test plan
- DATA_WIDTH=20, encode 20'h00001 → enc_parity_q=6'h07 one cycle later; 20'h00000 → 6'h00.
- Decode dec_data=20'h00001, dec_parity=6'h00 → after 2 cycles out_data=20'h00000, out_sbit=1, sbit_cnt=1, err_syn=6'h07, err_vld=1.
- Decode 20'h00003 with parity 6'h00 → syndrome 6'h0C, out_dbit=1, out_data=20'h00003, dbit_cnt=1; err_syn stays 6'h07.
- Decode clean 20'hABCDE with its true parity and one flipped check bit → out_sbit=1, data unchanged. Same word with dec_bypass=1 → flags 0, no count.
- Stream 8 words, hold out_ready low for 3 cycles mid-stream → no loss or duplication, dec_ready drops within a cycle, order preserved.
- Counter saturation: CNT_WIDTH=2, feed 5 single errors → sbit_cnt=3. Assert cnt_clr together with an error transfer → sbit_cnt=0, err_vld=0.
